fp16_operand_loader: RTL and testbench
======================================

// Module: fp16_operand_loader
// PURPOSE
// - Upstream stage of the logarithmic FP16 multiplier core.
// - Assembles two 16-bit FP16 operands (A, B) from byte-serial 8-bit pads, low byte first, A and B in parallel.
// - Presents each assembled pair to the multiplier over a valid/ready handshake.
// - Adds a byte-pair timeout, drop detection and optional operand classification.
// PARAMETERS
// - TIMEOUT_CYC  16  cycles allowed between low and high byte; 0 = timeout disabled
// - CNT_W        8   width of the saturating dropped-byte counter
// PORTS
// - clk          in   1      single clock, all logic rising-edge
// - rst          in   1      asynchronous, active-high reset
// - byte_valid   in   1      a_byte/b_byte carry a byte pair this cycle
// - a_byte       in   8      operand A byte (ui_in side)
// - b_byte       in   8      operand B byte (uio_in side)
// - op_valid     out  1      op_a/op_b/classes hold a complete pair
// - op_ready     in   1      multiplier core accepts the pair
// - op_a         out  16     assembled operand A {high,low}
// - op_b         out  16     assembled operand B {high,low}
// - a_class      out  3      A class: 000 normal, 001 zero, 010 subnormal, 011 inf, 100 NaN
// - b_class      out  3      B class, same encoding
// - timeout      out  1      one-cycle pulse: half-assembled pair discarded
// - drop         out  1      one-cycle pulse: byte pair discarded
// - drop_cnt     out  CNT_W  saturating count of drop pulses
// BEHAVIOUR
// - Reset: state=LOW, op_valid=0, op_a=op_b=0, a_class=b_class=000, timeout=drop=0, drop_cnt=0, timer=0.
// - State LOW: byte_valid -> capture low bytes, timer=0, go HIGH.
// - State HIGH, byte_valid: capture high bytes; on that same edge load op_a/op_b (and classes) and set op_valid=1; go HOLD.
// - Latency: op_valid is 1 in the cycle after the edge that sampled the high byte.
// - State HIGH, no byte_valid: timer increments. When TIMEOUT_CYC!=0 and timer reaches TIMEOUT_CYC-1:
//   - discard the low byte, pulse timeout, go LOW.
// - State HOLD: op_valid=1; op_a/op_b/classes stable until the transfer.
//   - Transfer = op_valid & op_ready at a rising edge.
// - HOLD, transfer and no byte_valid: op_valid->0, go LOW.
// - HOLD, transfer and byte_valid in the same cycle: bytes captured as the next low byte, go HIGH. No bubble, no drop.
// - HOLD, byte_valid without transfer: byte discarded, drop pulses, drop_cnt+1 (saturates at all-ones), stay HOLD.
// - Timeout and drop never assert in the same cycle.
// - op_ready is ignored outside HOLD.
// - Reset mid-operation: any partial byte and any pending pair are lost; outputs take reset values immediately (async).
// - Classes come from the exponent/mantissa fields of the assembled word:
//   - exp=0,man=0 zero; exp=0,man!=0 subnormal; exp=31,man=0 inf; exp=31,man!=0 NaN; else normal.
//   - The sign bit is ignored.
// CONFIGURATION
// - FP16_CLASSIFY_EN defined: a_class/b_class are registered alongside op_a/op_b as above.
// - FP16_CLASSIFY_EN undefined:
//   - classifier logic is not built and a_class=b_class=000 constantly.
//   - all other behaviour is identical.
// TESTING
// - Reset, then bytes (A,B) = (00,00), then (3E,42) on consecutive cycles, op_ready=1
//   -> op_valid=1 for 1 cycle, op_a=3E00, op_b=4200, classes 000/000.
// - Pair (00,00),(00,7C) with op_ready=0 for 5 cycles
//   -> op_valid held 5 cycles, op_a=0000 class 001, op_b=7C00 class 011 (with FP16_CLASSIFY_EN).
// - HOLD with op_ready=0 plus 3 extra byte_valid cycles
//   -> 3 drop pulses, drop_cnt=3, op_a/op_b unchanged.
// - HOLD with op_ready=1 and byte_valid=1 in the same cycle
//   -> pair transferred; new low byte kept; next pair completes one byte later with no drop.
// - Low byte then 16 idle cycles (TIMEOUT_CYC=16)
//   -> timeout pulse exactly once, state LOW, next two bytes form a fresh pair.
// - Assert rst while in HIGH and again while in HOLD
//   -> op_valid=0 and outputs zero immediately; first pair after release assembles correctly.

Source files
------------

// File: rtl/fp16_operand_loader.sv
// Byte-serial FP16 operand pair loader feeding the log multiplier core over valid/ready.
// Optional operand classification is built when FP16_CLASSIFY_EN is defined.
module fp16_operand_loader #(
    parameter int unsigned TIMEOUT_CYC = 16,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             byte_valid,
    input  logic [7:0]       a_byte,
    input  logic [7:0]       b_byte,
    output logic             op_valid,
    input  logic             op_ready,
    output logic [15:0]      op_a,
    output logic [15:0]      op_b,
    output logic [2:0]       a_class,
    output logic [2:0]       b_class,
    output logic             timeout,
    output logic             drop,
    output logic [CNT_W-1:0] drop_cnt
);

    typedef enum logic [1:0] {S_LOW, S_HIGH, S_HOLD} state_t;

    localparam int unsigned TMR_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    state_t           r_state;
    state_t           w_state_nxt;
    logic [TMR_W-1:0] r_timer;
    logic [7:0]       r_a_lo;
    logic [7:0]       r_b_lo;
    logic [15:0]      r_op_a;
    logic [15:0]      r_op_b;
    logic             r_timeout;
    logic             r_drop;
    logic [CNT_W-1:0] r_drop_cnt;

    logic w_expire;
    logic w_cap_low;
    logic w_cap_high;
    logic w_tmo;
    logic w_drp;

    assign w_expire = (TIMEOUT_CYC != 0) && (r_timer == TMR_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_LOW;
        else     r_state <= w_state_nxt;
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_LOW:   if (byte_valid) w_state_nxt = S_HIGH;
            S_HIGH: begin
                if (byte_valid)    w_state_nxt = S_HOLD;
                else if (w_expire) w_state_nxt = S_LOW;
            end
            S_HOLD:  if (op_ready) w_state_nxt = byte_valid ? S_HIGH : S_LOW;
            default: w_state_nxt = S_LOW;
        endcase
    end

    // A byte arriving on the transfer edge becomes the next low byte, so HOLD can chain without a bubble.
    always_comb begin
        w_cap_low  = byte_valid && ((r_state == S_LOW) || ((r_state == S_HOLD) && op_ready));
        w_cap_high = byte_valid && (r_state == S_HIGH);
        w_tmo      = !byte_valid && (r_state == S_HIGH) && w_expire;
        w_drp      = byte_valid && !op_ready && (r_state == S_HOLD);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_timer    <= '0;
            r_a_lo     <= '0;
            r_b_lo     <= '0;
            r_op_a     <= '0;
            r_op_b     <= '0;
            r_timeout  <= 1'b0;
            r_drop     <= 1'b0;
            r_drop_cnt <= '0;
        end else begin
            r_timeout <= w_tmo;
            r_drop    <= w_drp;
            if (w_cap_low) begin
                r_a_lo  <= a_byte;
                r_b_lo  <= b_byte;
                r_timer <= '0;
            end else if ((r_state == S_HIGH) && !byte_valid) begin
                r_timer <= r_timer + 1'b1;
            end
            if (w_cap_high) begin
                r_op_a <= {a_byte, r_a_lo};
                r_op_b <= {b_byte, r_b_lo};
            end
            if (w_drp && (r_drop_cnt != '1)) r_drop_cnt <= r_drop_cnt + 1'b1;
        end
    end

`ifdef FP16_CLASSIFY_EN
    logic [2:0] r_a_class;
    logic [2:0] r_b_class;

    function automatic logic [2:0] classify(input logic [15:0] w);
        logic [4:0] w_exp;
        logic [9:0] w_man;
        w_exp = w[14:10];
        w_man = w[9:0];
        if (w_exp == 5'd0)       classify = (w_man == '0) ? 3'b001 : 3'b010;
        else if (w_exp == 5'h1F) classify = (w_man == '0) ? 3'b011 : 3'b100;
        else                     classify = 3'b000;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_a_class <= '0;
            r_b_class <= '0;
        end else if (w_cap_high) begin
            r_a_class <= classify({a_byte, r_a_lo});
            r_b_class <= classify({b_byte, r_b_lo});
        end
    end

    assign a_class = r_a_class;
    assign b_class = r_b_class;
`else
    assign a_class = '0;
    assign b_class = '0;
`endif

    assign op_valid = (r_state == S_HOLD);
    assign op_a     = r_op_a;
    assign op_b     = r_op_b;
    assign timeout  = r_timeout;
    assign drop     = r_drop;
    assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_fp16_operand_loader.sv
// Scoreboard bench for fp16_operand_loader: directed byte pairs, transfers checked by a separate monitor.
module tb_fp16_operand_loader;

    typedef struct packed {
        logic [15:0] a;
        logic [15:0] b;
        logic [2:0]  ac;
        logic [2:0]  bc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst;
    logic       byte_valid;
    logic [7:0] a_byte;
    logic [7:0] b_byte;
    logic       op_valid;
    logic       op_ready;
    logic [15:0] op_a;
    logic [15:0] op_b;
    logic [2:0] a_class;
    logic [2:0] b_class;
    logic       timeout;
    logic       drop;
    logic [7:0] drop_cnt;

    int   checks   = 0;
    int   failures = 0;
    exp_t sb_q[$];

    fp16_operand_loader #(.TIMEOUT_CYC(16), .CNT_W(8)) dut (
        .clk(clk), .rst(rst), .byte_valid(byte_valid), .a_byte(a_byte), .b_byte(b_byte),
        .op_valid(op_valid), .op_ready(op_ready), .op_a(op_a), .op_b(op_b),
        .a_class(a_class), .b_class(b_class), .timeout(timeout), .drop(drop), .drop_cnt(drop_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    function automatic logic [2:0] cls(input logic [2:0] c);
`ifdef FP16_CLASSIFY_EN
        return c;
`else
        return 3'b000;
`endif
    endfunction

    // Called at a negedge: drive inputs, let one rising edge pass, return at the next negedge.
    task automatic step(input logic bv, input logic [7:0] a, input logic [7:0] b, input logic rdy);
        byte_valid = bv;
        a_byte     = a;
        b_byte     = b;
        op_ready   = rdy;
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic push(input logic [15:0] a, input logic [15:0] b, input logic [2:0] ac, input logic [2:0] bc);
        exp_t e;
        e.a  = a;
        e.b  = b;
        e.ac = cls(ac);
        e.bc = cls(bc);
        sb_q.push_back(e);
    endtask

    // Monitor: a transfer happens on the next rising edge whenever valid and ready are both high here.
    initial begin
        forever begin
            @(negedge clk);
            #2;
            if (rst === 1'b0 && op_valid === 1'b1 && op_ready === 1'b1) begin
                if (sb_q.size() == 0) begin
                    chk("sb_unexpected_pair", {op_a, op_b}, 32'hFFFF_FFFF);
                end else begin
                    exp_t e;
                    e = sb_q.pop_front();
                    chk("sb_op_a", op_a, e.a);
                    chk("sb_op_b", op_b, e.b);
                    chk("sb_a_class", a_class, e.ac);
                    chk("sb_b_class", b_class, e.bc);
                end
            end
        end
    end

    initial begin
        int tmo_seen;
        rst = 1'b1;
        byte_valid = 1'b0;
        a_byte = '0;
        b_byte = '0;
        op_ready = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        chk("rst_op_valid", op_valid, 0);
        chk("rst_op_a", op_a, 0);
        chk("rst_op_b", op_b, 0);
        chk("rst_classes", {a_class, b_class}, 0);
        chk("rst_pulses", {timeout, drop}, 0);
        chk("rst_drop_cnt", drop_cnt, 0);

        // Basic pair, ready held high: valid for exactly one cycle.
        push(16'h3E00, 16'h4200, 3'b000, 3'b000);
        step(1'b1, 8'h00, 8'h00, 1'b1);
        chk("p1_not_valid_after_low", op_valid, 0);
        step(1'b1, 8'h3E, 8'h42, 1'b1);
        chk("p1_valid", op_valid, 1);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        chk("p1_valid_one_cycle", op_valid, 0);

        // Zero / inf pair held with ready low for 5 cycles.
        push(16'h0000, 16'h7C00, 3'b001, 3'b011);
        step(1'b1, 8'h00, 8'h00, 1'b0);
        step(1'b1, 8'h00, 8'h7C, 1'b0);
        for (int i = 0; i < 5; i++) begin
            chk("p2_hold_valid", op_valid, 1);
            chk("p2_hold_b", op_b, 16'h7C00);
            step(1'b0, 8'h00, 8'h00, 1'b0);
        end
        chk("p2_still_valid", op_valid, 1);

        // Three bytes arriving in HOLD without ready are dropped.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 8'hFF, 8'hFF, 1'b0);
            chk("drop_pulse", drop, 1);
            chk("drop_no_timeout", timeout, 0);
        end
        step(1'b0, 8'h00, 8'h00, 1'b0);
        chk("drop_pulse_end", drop, 0);
        chk("drop_cnt_3", drop_cnt, 3);
        chk("drop_op_a_kept", op_a, 16'h0000);
        chk("drop_op_b_kept", op_b, 16'h7C00);
        chk("drop_valid_kept", op_valid, 1);

        // Transfer and new low byte on the same edge.
        step(1'b1, 8'h11, 8'h22, 1'b1);
        chk("chain_valid_low", op_valid, 0);
        chk("chain_no_drop", drop, 0);
        push(16'h3C11, 16'h4522, 3'b000, 3'b000);
        step(1'b1, 8'h3C, 8'h45, 1'b0);
        chk("chain_valid", op_valid, 1);
        chk("chain_drop_cnt", drop_cnt, 3);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        chk("chain_done", op_valid, 0);

        // Timeout: low byte then 16 idle cycles.
        tmo_seen = 0;
        step(1'b1, 8'hAA, 8'hBB, 1'b1);
        for (int k = 1; k <= 18; k++) begin
            step(1'b0, 8'h00, 8'h00, 1'b1);
            chk("tmo_at_cycle", timeout, (k == 16) ? 1 : 0);
            chk("tmo_no_valid", op_valid, 0);
            if (timeout === 1'b1) tmo_seen++;
        end
        chk("tmo_once", tmo_seen, 1);
        push(16'h3C00, 16'h4000, 3'b000, 3'b000);
        step(1'b1, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'h3C, 8'h40, 1'b1);
        chk("tmo_fresh_valid", op_valid, 1);
        step(1'b0, 8'h00, 8'h00, 1'b1);

        // Reset while in HIGH.
        step(1'b1, 8'h12, 8'h34, 1'b0);
        rst = 1'b1;
        #1;
        chk("rstH_op_valid", op_valid, 0);
        chk("rstH_op_a", op_a, 0);
        chk("rstH_op_b", op_b, 0);
        chk("rstH_drop_cnt", drop_cnt, 0);
        @(negedge clk);
        rst = 1'b0;

        // Reset while in HOLD; this pair is lost.
        step(1'b1, 8'h01, 8'h02, 1'b0);
        step(1'b1, 8'h03, 8'h04, 1'b0);
        chk("pre_rst_hold_a", op_a, 16'h0301);
        rst = 1'b1;
        #1;
        chk("rstP_op_valid", op_valid, 0);
        chk("rstP_op_a", op_a, 0);
        chk("rstP_op_b", op_b, 0);
        chk("rstP_classes", {a_class, b_class}, 0);
        @(negedge clk);
        rst = 1'b0;

        // Fresh pairs after reset: normal/inf, then subnormal/NaN.
        push(16'hC000, 16'hFC00, 3'b000, 3'b011);
        step(1'b1, 8'h00, 8'h00, 1'b1);
        step(1'b1, 8'hC0, 8'hFC, 1'b1);
        chk("post_rst_valid", op_valid, 1);
        push(16'h0001, 16'h7E00, 3'b010, 3'b100);
        step(1'b1, 8'h01, 8'h00, 1'b1);
        step(1'b1, 8'h00, 8'h7E, 1'b1);
        chk("last_valid", op_valid, 1);
        step(1'b0, 8'h00, 8'h00, 1'b1);
        step(1'b0, 8'h00, 8'h00, 1'b0);

        chk("sb_empty", sb_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
